bnn_host_seq: RTL

BNN_HOST_SEQ -- requirements
Module: bnn_host_seq

---
 rtl/bnn_host_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bnn_host_seq.sv
// Host-side sequencer: streams activation/weight byte pairs into a BNN neuron, waits for done, holds the result.
// Optional macro BNN_HOST_CHECK_EN adds a local XNOR-popcount model and flags neuron/model mismatches.
module bnn_host_seq #(
    parameter int N_WORDS = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_act,
    input  logic [7:0] cmd_wgt,
    output logic [7:0] nrn_ui_in,
    output logic [7:0] nrn_uio_in,
    output logic       nrn_ena,
    input  logic [7:0] nrn_uo_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [6:0] res_data,
    output logic       res_timeout,
    output logic       res_mismatch
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;

    localparam logic [3:0] LAST_WORD = 4'(N_WORDS - 1);
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [3:0] word_cnt;
    logic [7:0] wait_cnt;
    logic       xfer, last_word, cap_done, cap_to, rel;

    assign xfer      = cmd_valid & cmd_ready;
    assign last_word = (word_cnt == LAST_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        cap_done  = 1'b0;
        cap_to    = 1'b0;
        rel       = 1'b0;
        case (state)
            IDLE, LOAD: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = last_word ? WAIT : LOAD;
            end
            WAIT: begin
                // first WAIT cycle overlaps the final load strobe, so done is not trusted yet
                if (wait_cnt != 8'd0 && nrn_uo_out[7]) begin
                    cap_done  = 1'b1;
                    state_nxt = HOLD;
                end else if (wait_cnt == LAST_WAIT) begin
                    cap_to    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    rel       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt    <= '0;
            wait_cnt    <= '0;
            nrn_ui_in   <= '0;
            nrn_uio_in  <= '0;
            nrn_ena     <= 1'b0;
            res_data    <= '0;
            res_timeout <= 1'b0;
        end else begin
            nrn_ena <= xfer;
            if (xfer) begin
                nrn_ui_in  <= cmd_act;
                nrn_uio_in <= cmd_wgt;
                word_cnt   <= last_word ? 4'd0 : word_cnt + 4'd1;
            end
            wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
            if (cap_done) begin
                res_data    <= nrn_uo_out[6:0];
                res_timeout <= 1'b0;
            end else if (cap_to) begin
                res_data    <= '0;
                res_timeout <= 1'b1;
            end else if (rel) begin
                res_data    <= '0;
                res_timeout <= 1'b0;
            end
        end
    end

`ifdef BNN_HOST_CHECK_EN
    logic [6:0] model_acc;
    logic [3:0] pair_pop;

    always_comb begin
        logic [7:0] agree;
        agree    = ~(cmd_act ^ cmd_wgt);
        pair_pop = '0;
        for (int i = 0; i < 8; i++) pair_pop = pair_pop + {3'b0, agree[i]};
    end

    // model is cleared on the HOLD->IDLE edge, so the next evaluation starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            model_acc    <= '0;
            res_mismatch <= 1'b0;
        end else begin
            if (rel)       model_acc <= '0;
            else if (xfer) model_acc <= model_acc + {3'b0, pair_pop};
            if (cap_done)          res_mismatch <= (nrn_uo_out[6:0] != model_acc);
            else if (cap_to | rel) res_mismatch <= 1'b0;
        end
    end
`else
    assign res_mismatch = 1'b0;
`endif

endmodule
